// File: rtl/pb_cmd_pkg.sv
// Shared types and constants for the peripheral-bus command dispatcher.
//   opcode_e       host command opcodes (values 5..7 are illegal)
//   state_e        dispatcher FSM states
//   rsp_bytes_t    4 x 8-bit byte bundle, byte n = bits [8n+7:8n]
//   RSP_*          single-byte status responses
package pb_cmd_pkg;

    localparam int unsigned MAX_RSP_BYTES = 4;
    localparam int unsigned NUM_OPS       = 5;
    localparam int unsigned RSP_LEN_W     = 3;

    localparam logic [7:0] RSP_ACK     = 8'h4B;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;
    localparam logic [7:0] RSP_BADOP   = 8'hEF;

    typedef logic [MAX_RSP_BYTES-1:0][7:0] rsp_bytes_t;

    typedef enum logic [2:0] {
        OP_WRITE4 = 3'd0,
        OP_READ4  = 3'd1,
        OP_ADC4   = 3'd2,
        OP_ADC1   = 3'd3,
        OP_TEST   = 3'd4
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_REJECT    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_STREAM    = 3'd5
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'(OP_TEST);
    endfunction

    // One-hot activation vector; bit index equals the opcode value.
    function automatic logic [NUM_OPS-1:0] op_onehot(input logic [2:0] op);
        logic [NUM_OPS-1:0] oh;
        oh = '0;
        if (op_is_legal(op)) oh[op] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pb_response_serializer.sv
// Streams a 1..4 byte response over a valid/ready handshake.
//   load/load_bytes/load_len  capture a new response (len must be 1..4)
//   rsp_valid/rsp_ready       byte handshake, rsp_data held while stalled
//   rsp_last                  high on the final byte
//   done                      one-cycle pulse after the final transfer
module pb_response_serializer
    import pb_cmd_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  rsp_bytes_t           load_bytes,
    input  logic [RSP_LEN_W-1:0] load_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_last,
    output logic                 done
);

    rsp_bytes_t           byte_q;
    logic [RSP_LEN_W-1:0] idx_q;
    logic [RSP_LEN_W-1:0] len_q;

    // Output byte is registered; the next one is fetched on each accepted transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                byte_q    <= load_bytes;
                len_q     <= load_len;
                idx_q     <= '0;
                rsp_valid <= 1'b1;
                rsp_data  <= load_bytes[0];
                rsp_last  <= (load_len == RSP_LEN_W'(1));
            end else if (rsp_valid && rsp_ready) begin
                if (rsp_last) begin
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    idx_q    <= idx_q + RSP_LEN_W'(1);
                    rsp_data <= byte_q[2'(idx_q + RSP_LEN_W'(1))];
                    rsp_last <= ((idx_q + RSP_LEN_W'(2)) == len_q);
                end
            end
        end
    end

endmodule

// File: rtl/pb_command_dispatcher.sv
// Dispatches one parsed host command to the matching peripheral-bus state
// machine, watches for completion with a timeout, and streams the response.
//   cmd_*                        command handshake and payload
//   substate_pb_*_active         one-hot activation levels
//   substate_pb_*_complete       completion inputs (only the selected one is used)
//   command_param_data/CommandType  latched command parameters
//   ResponseBytes/ResponseByteCount response from the selected machine
//   rsp_*                        response byte stream to UART TX
//   busy, err_timeout, err_opcode status
module pb_command_dispatcher
    import pb_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 27000000,
    parameter int unsigned TIMEOUT_US      = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [1:0]  cmd_type,
    input  logic [31:0] cmd_param,
    output logic        substate_pb_i_write4_active,
    output logic        substate_pb_read4_active,
    output logic        substate_pb_adc4_active,
    output logic        substate_pb_adc1_active,
    output logic        substate_pb_test_active,
    input  logic        substate_pb_i_write4_complete,
    input  logic        substate_pb_read4_complete,
    input  logic        substate_pb_adc4_complete,
    input  logic        substate_pb_adc1_complete,
    input  logic        substate_pb_test_complete,
    output rsp_bytes_t  command_param_data,
    output logic [1:0]  CommandType,
    input  rsp_bytes_t  ResponseBytes,
    input  logic [3:0]  ResponseByteCount,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_opcode
);

    localparam int unsigned WD_W           = 32;
    localparam int unsigned TIMEOUT_CYCLES = (CLOCK_FREQUENCY / 1000000) * TIMEOUT_US;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [2:0]           opcode_q, opcode_d;
    logic [NUM_OPS-1:0]   active_q, active_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    rsp_bytes_t           rsp_buf_q, rsp_buf_d;
    logic [RSP_LEN_W-1:0] rsp_len_q, rsp_len_d;
    logic                 ser_load_q, ser_load_d;
    rsp_bytes_t           params_d;
    logic [1:0]           type_d;
    logic                 err_timeout_d, err_opcode_d;
    logic                 cmd_ready_d;
    logic [NUM_OPS-1:0]   complete_vec;
    logic                 ser_done;

    assign complete_vec = {substate_pb_test_complete, substate_pb_adc1_complete,
                           substate_pb_adc4_complete, substate_pb_read4_complete,
                           substate_pb_i_write4_complete};

    assign substate_pb_i_write4_active = active_q[0];
    assign substate_pb_read4_active    = active_q[1];
    assign substate_pb_adc4_active     = active_q[2];
    assign substate_pb_adc1_active     = active_q[3];
    assign substate_pb_test_active     = active_q[4];

    // Next-state, watchdog and response-capture logic.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        active_d      = active_q;
        wd_cnt_d      = wd_cnt_q;
        rsp_buf_d     = rsp_buf_q;
        rsp_len_d     = rsp_len_q;
        ser_load_d    = 1'b0;
        params_d      = command_param_data;
        type_d        = CommandType;
        err_timeout_d = 1'b0;
        err_opcode_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    params_d = cmd_param;
                    type_d   = cmd_type;
                    opcode_d = cmd_opcode;
                    state_d  = op_is_legal(cmd_opcode) ? ST_LAUNCH : ST_REJECT;
                end
            end
            ST_LAUNCH: begin
                active_d = op_onehot(opcode_q);
                wd_cnt_d = '0;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Completion takes priority over a coincident watchdog expiry.
                if ((complete_vec & active_q) != '0) begin
                    active_d = '0;
                    state_d  = ST_CAPTURE;
                end else if (wd_cnt_q == WD_LAST) begin
                    active_d      = '0;
                    err_timeout_d = 1'b1;
                    rsp_buf_d     = '0;
                    rsp_buf_d[0]  = RSP_TIMEOUT;
                    rsp_len_d     = RSP_LEN_W'(1);
                    ser_load_d    = 1'b1;
                    state_d       = ST_STREAM;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_buf_d  = ResponseBytes;
                ser_load_d = 1'b1;
                state_d    = ST_STREAM;
                if (ResponseByteCount == 4'd0) begin
                    rsp_buf_d    = '0;
                    rsp_buf_d[0] = RSP_ACK;
                    rsp_len_d    = RSP_LEN_W'(1);
                end else if (ResponseByteCount >= 4'(MAX_RSP_BYTES)) begin
                    rsp_len_d = RSP_LEN_W'(MAX_RSP_BYTES);
                end else begin
                    rsp_len_d = RSP_LEN_W'(ResponseByteCount);
                end
            end
            ST_REJECT: begin
                err_opcode_d = 1'b1;
                rsp_buf_d    = '0;
                rsp_buf_d[0] = RSP_BADOP;
                rsp_len_d    = RSP_LEN_W'(1);
                ser_load_d   = 1'b1;
                state_d      = ST_STREAM;
            end
            ST_STREAM: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            opcode_q           <= '0;
            active_q           <= '0;
            wd_cnt_q           <= '0;
            rsp_buf_q          <= '0;
            rsp_len_q          <= '0;
            ser_load_q         <= 1'b0;
            command_param_data <= '0;
            CommandType        <= '0;
            err_timeout        <= 1'b0;
            err_opcode         <= 1'b0;
            cmd_ready          <= 1'b1;
            busy               <= 1'b0;
        end else begin
            state_q            <= state_d;
            opcode_q           <= opcode_d;
            active_q           <= active_d;
            wd_cnt_q           <= wd_cnt_d;
            rsp_buf_q          <= rsp_buf_d;
            rsp_len_q          <= rsp_len_d;
            ser_load_q         <= ser_load_d;
            command_param_data <= params_d;
            CommandType        <= type_d;
            err_timeout        <= err_timeout_d;
            err_opcode         <= err_opcode_d;
            cmd_ready          <= cmd_ready_d;
            busy               <= !cmd_ready_d;
        end
    end

    pb_response_serializer u_serializer (
        .clock      (clock),
        .reset      (reset),
        .load       (ser_load_q),
        .load_bytes (rsp_buf_q),
        .load_len   (rsp_len_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .done       (ser_done)
    );

endmodule
